// File: rtl/score_pkg.sv
// Shared types and helpers for the score binary-to-BCD converter.
package score_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int DIGIT_W = 4;

  function automatic logic [31:0] pow10(input int n);
    logic [31:0] r;
    r = 32'd1;
    for (int i = 0; i < n; i++) r = r * 32'd10;
    return r;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// One double-dabble correction cell: a BCD digit of 5 or more gets 3 added.
module bcd_add3
  import score_pkg::*;
(
  input  logic [DIGIT_W-1:0] d,
  output logic [DIGIT_W-1:0] q
);

  assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/score_bin2bcd.sv
// Sequential double-dabble converter from the binary score to packed BCD digits,
// with saturation at the largest displayable value and leading-zero blanking.
module score_bin2bcd
  import score_pkg::*;
#(
  parameter int WIDTH  = 10,
  parameter int DIGITS = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          bin,
  output logic                      out_valid,
  output logic [DIGIT_W*DIGITS-1:0] digits,
  output logic                      ovf,
  output logic [DIGITS-1:0]         blank
);

  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [31:0] MAX = pow10(DIGITS) - 32'd1;
  localparam logic [BCD_W-1:0] ALL9 = {DIGITS{4'h9}};

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   sreg;
  logic [BCD_W-1:0]   acc;
  logic [BCD_W-1:0]   adj;
  logic               ovf_next;
  logic               accept;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .d (acc[g*DIGIT_W +: DIGIT_W]),
      .q (adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = SHIFT;
      SHIFT:   if (cnt == CNT_W'(1)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      sreg      <= '0;
      acc       <= '0;
      ovf_next  <= 1'b0;
      digits    <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            sreg     <= bin;
            acc      <= '0;
            cnt      <= CNT_W'(WIDTH);
            // 32-bit compare so small WIDTH never truncates MAX
            ovf_next <= (32'(bin) > MAX);
          end
        end
        SHIFT: begin
          // Corrected digits shift left as one register; the top bit falls off.
          acc  <= {adj[BCD_W-2:0], sreg[WIDTH-1]};
          sreg <= sreg << 1;
          cnt  <= cnt - CNT_W'(1);
        end
        DONE: begin
          digits    <= ovf_next ? ALL9 : acc;
          ovf       <= ovf_next;
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Blank a digit only while every more-significant digit is also zero.
  always_comb begin
    logic run;
    blank = '0;
    run   = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      run      = run && (digits[i*DIGIT_W +: DIGIT_W] == 4'd0);
      blank[i] = run;
    end
  end

endmodule

// File: tb/tb_score_bin2bcd.sv
// Directed bench for score_bin2bcd at default size plus a WIDTH=4/DIGITS=2 instance.
`timescale 1ns/1ps
module tb_score_bin2bcd;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  bin;
  logic        out_valid;
  logic [11:0] digits;
  logic        ovf;
  logic [2:0]  blank;

  logic        in_valid2;
  logic        in_ready2;
  logic [3:0]  bin2;
  logic        out_valid2;
  logic [7:0]  digits2;
  logic        ovf2;
  logic [1:0]  blank2;

  int nvec = 0;
  int nmis = 0;
  int pulses = 0;
  longint acc_t[$];

  always #5 clk = ~clk;

  score_bin2bcd #(.WIDTH(10), .DIGITS(3)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .bin(bin),
    .out_valid(out_valid), .digits(digits), .ovf(ovf), .blank(blank)
  );

  score_bin2bcd #(.WIDTH(4), .DIGITS(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2), .bin(bin2),
    .out_valid(out_valid2), .digits(digits2), .ovf(ovf2), .blank(blank2)
  );

  always @(posedge clk) begin
    if (out_valid) pulses++;
    if (reset && in_valid && in_ready) acc_t.push_back($time);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] ref_d(input int v);
    if (v > 999) return 12'h999;
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [2:0] ref_b(input logic [11:0] d);
    return {d[11:8] == 4'd0, (d[11:8] == 4'd0) && (d[7:4] == 4'd0), 1'b0};
  endfunction

  task automatic wait_ov(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Called at posedge+1 with the converter idle.
  task automatic conv(input logic [9:0] v, input logic [11:0] ed, input logic eo,
                      input logic [2:0] eb, input string tag);
    int lat;
    chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
    bin = v;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    bin = ~v;
    wait_ov(lat);
    chk({tag, " latency"}, 32'(lat), 32'd11);
    chk({tag, " digits"}, 32'(digits), 32'(ed));
    chk({tag, " ovf"}, 32'(ovf), 32'(eo));
    chk({tag, " blank"}, 32'(blank), 32'(eb));
    @(posedge clk); #1;
    chk({tag, " pulse width"}, 32'(out_valid), 32'd0);
  endtask

  task automatic conv2(input logic [3:0] v, input string tag);
    int lat;
    logic [7:0] ed;
    ed = {4'(v / 10), 4'(v % 10)};
    bin2 = v;
    in_valid2 = 1'b1;
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    bin2 = ~v;
    lat = 0;
    while (!out_valid2 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'd5);
    chk({tag, " digits"}, 32'(digits2), 32'(ed));
    chk({tag, " ovf"}, 32'(ovf2), 32'd0);
    chk({tag, " blank"}, 32'(blank2), {30'd0, ed[7:4] == 4'd0, 1'b0});
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    int p0;
    int waited;
    reset = 1'b0;
    in_valid = 1'b0;
    bin = '0;
    in_valid2 = 1'b0;
    bin2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset digits", 32'(digits), 32'd0);
    chk("reset ovf", 32'(ovf), 32'd0);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset blank", 32'(blank), 32'b110);
    reset = 1'b1;
    @(posedge clk); #1;

    conv(10'd0,    12'h000, 1'b0, 3'b110, "zero");
    conv(10'd137,  12'h137, 1'b0, 3'b000, "137");
    conv(10'd7,    12'h007, 1'b0, 3'b110, "7");
    conv(10'd42,   12'h042, 1'b0, 3'b100, "42");
    conv(10'd999,  12'h999, 1'b0, 3'b000, "999");
    conv(10'd1000, 12'h999, 1'b1, 3'b000, "1000");
    conv(10'd1023, 12'h999, 1'b1, 3'b000, "1023");
    conv(10'd100,  12'h100, 1'b0, 3'b000, "100");

    // back-to-back requests with in_valid held high
    acc_t.delete();
    p0 = pulses;
    bin = 10'd42;
    in_valid = 1'b1;
    waited = 0;
    while (acc_t.size() < 1 && waited < 5) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("b2b first accept", 32'(acc_t.size()), 32'd1);
    bin = 10'd7;
    wait_ov(lat);
    chk("b2b first digits", 32'(digits), 32'h042);
    waited = 0;
    while (acc_t.size() < 2 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    in_valid = 1'b0;
    chk("b2b second accept", 32'(acc_t.size()), 32'd2);
    if (acc_t.size() >= 2)
      chk("b2b spacing ns", 32'(acc_t[1] - acc_t[0]), 32'd120);
    bin = 10'd555;
    wait_ov(lat);
    chk("b2b second digits", 32'(digits), 32'h007);
    chk("b2b second blank", 32'(blank), 32'b110);
    repeat (15) @(posedge clk);
    #1;
    chk("b2b pulse count", 32'(pulses - p0), 32'd2);
    chk("b2b accept count", 32'(acc_t.size()), 32'd2);

    // reset in the middle of a conversion
    p0 = pulses;
    bin = 10'd500;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("midrst digits", 32'(digits), 32'd0);
    chk("midrst in_ready", 32'(in_ready), 32'd1);
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    chk("midrst blank", 32'(blank), 32'b110);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    chk("midrst no pulse", 32'(pulses - p0), 32'd0);
    conv(10'd321, 12'h321, 1'b0, 3'b000, "after reset 321");

    for (int v = 0; v < 1024; v++)
      conv(10'(v), ref_d(v), v > 999, ref_b(ref_d(v)), $sformatf("sweep %0d", v));

    for (int v = 0; v < 16; v++)
      conv2(4'(v), $sformatf("w4d2 %0d", v));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
